// File: rtl/cpu_dbg_ctrl.sv
// Run-control sequencer for the one-cycle CPU: halt, run, N-step and a single
// PC breakpoint, all gated through one execute-enable (CPU_EN).
module cpu_dbg_ctrl #(
   parameter int PC_WIDTH   = 8,
   parameter int CNT_WIDTH  = 8,
   parameter int ICNT_WIDTH = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [PC_WIDTH-1:0]   PC,
   input  logic                  CMD_VALID,
   input  logic [1:0]            CMD,
   input  logic [CNT_WIDTH-1:0]  STEP_N,
   input  logic                  BP_SET,
   input  logic [PC_WIDTH-1:0]   BP_ADDR,
   output logic                  CPU_EN,
   output logic                  HALTED,
   output logic                  BP_HIT,
   output logic [1:0]            STATE,
   output logic [ICNT_WIDTH-1:0] INSTR_CNT
);

   typedef enum logic [1:0] {
      S_HALT = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10,
      S_BRK  = 2'b11
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [PC_WIDTH-1:0]   bp_reg_q, bp_reg_d;
   logic                  bp_armed_q, bp_armed_d;
   logic                  bp_skip_q, bp_skip_d;
   logic                  bp_hit_q, bp_hit_d;
   logic [ICNT_WIDTH-1:0] icnt_q, icnt_d;

   logic active, bp_match, cpu_en, stop;
   logic cmd_halt, cmd_run, cmd_step, cmd_clr, resume;

   always_comb begin
      active   = (state_q == S_RUN) || (state_q == S_STEP);
      bp_match = bp_armed_q && (PC == bp_reg_q) && !bp_skip_q;
      cpu_en   = active && !bp_match;
      stop     = active && bp_match;
      cmd_halt = CMD_VALID && (CMD == 2'b00);
      cmd_run  = CMD_VALID && (CMD == 2'b01);
      cmd_step = CMD_VALID && (CMD == 2'b10);
      cmd_clr  = CMD_VALID && (CMD == 2'b11);
      resume   = (cmd_run || cmd_step) && (state_q == S_BRK);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_HALT;
         cnt_q      <= '0;
         bp_reg_q   <= '0;
         bp_armed_q <= 1'b0;
         bp_skip_q  <= 1'b0;
         bp_hit_q   <= 1'b0;
         icnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bp_reg_q   <= bp_reg_d;
         bp_armed_q <= bp_armed_d;
         bp_skip_q  <= bp_skip_d;
         bp_hit_q   <= bp_hit_d;
         icnt_q     <= icnt_d;
      end
   end

   // Explicit HALT outranks a breakpoint stop, which outranks RUN/STEP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (cmd_halt) begin
         state_d = S_HALT;
         cnt_d   = '0;
      end else if (stop) begin
         state_d = S_BRK;
         cnt_d   = '0;
      end else if (cmd_run && (state_q != S_RUN)) begin
         state_d = S_RUN;
      end else if (cmd_step && (state_q != S_RUN)) begin
         state_d = S_STEP;
         cnt_d   = (STEP_N == '0) ? CNT_WIDTH'(1) : STEP_N;
      end else if ((state_q == S_STEP) && cpu_en) begin
         cnt_d = cnt_q - CNT_WIDTH'(1);
         if (cnt_q == CNT_WIDTH'(1)) state_d = S_HALT;
      end
   end

   // bp_skip lets the resumed instruction sitting on the breakpoint execute once.
   always_comb begin
      bp_reg_d   = bp_reg_q;
      bp_armed_d = bp_armed_q;
      bp_skip_d  = bp_skip_q;
      if (cpu_en) bp_skip_d = 1'b0;
      if (resume) bp_skip_d = 1'b1;
      if (cmd_clr) bp_armed_d = 1'b0;
      if (BP_SET) begin
         bp_reg_d   = BP_ADDR;
         bp_armed_d = 1'b1;
         bp_skip_d  = 1'b0;
      end
      bp_hit_d = stop;
      icnt_d   = icnt_q + ICNT_WIDTH'(cpu_en);
   end

   always_comb begin
      CPU_EN    = cpu_en;
      HALTED    = (state_q == S_HALT) || (state_q == S_BRK);
      BP_HIT    = bp_hit_q;
      STATE     = state_q;
      INSTR_CNT = icnt_q;
   end

endmodule
